mem_port_arbiter: RTL and testbench

Shares the core's single byte-wide memory bus between the instruction-fetch stream and renamed load/store micro-ops. Upstream of the frontend, it supplies the `instr`/`instr_valid`/`instr_ready` byte stream. It also serves the memory-op lane that type sorting currently ties off. It keeps one bus transaction in flight at a time, prioritises data ops, and bounds fetch starvation.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_resp_buf1.sv | 37 +++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: arbiter state encoding
// (readable by other units) and the physical-register tag width.
`ifndef PR_ADDR_W
`define PR_ADDR_W 6
`endif

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FETCH_WAIT = 2'd1,
    DATA_WAIT  = 2'd2
  } arb_state_t;

  localparam int PR_ADDR_W    = `PR_ADDR_W;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_resp_buf1.sv
// resp_buf1: one-entry valid/ready holding register. A push and a drain in
// the same cycle refill the entry; flush empties it.
module resp_buf1
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             free,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  input  logic             ready
);

  // Entry can accept new data when empty or being consumed this cycle.
  assign free = !valid || ready;

  // Holding register: flush beats push, push beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide memory bus between instruction fetch
// and load/store ops, one transaction in flight, data ops first.
// Optional feature macro: MEM_ARB_STARVE_EN (bounded fetch starvation via
// starve_cnt / STARVE_LIMIT). Undefined: strict data priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = `PR_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [15:0]      fetch_addr,
  output logic             fetch_ready,
  input  logic             fetch_flush,
  output logic [7:0]       instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             dreq_valid,
  output logic             dreq_ready,
  input  logic [15:0]      dreq_addr,
  input  logic [7:0]       dreq_wdata,
  input  logic             dreq_store,
  input  logic [TAG_W-1:0] dreq_tag,
  output logic             dresp_valid,
  input  logic             dresp_ready,
  output logic [7:0]       dresp_data,
  output logic [TAG_W-1:0] dresp_tag,
  output logic             dresp_store,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack
);

  localparam int DB_W = 8 + TAG_W + 1;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  arb_state_t      state, state_nxt;
  logic            squash;
  logic            fb_free, db_free;
  logic            f_elig, d_elig, fetch_forced;
  logic            grant_f, grant_d;
  logic            ack_f, ack_d, fb_push;
  logic            req_q, we_q, store_q;
  logic [15:0]     addr_q;
  logic [7:0]      wdata_q, ld_data;
  logic [TAG_W-1:0] tag_q;
  logic [DB_W-1:0] db_out;

  assign f_elig = fetch_valid && fb_free;
  assign d_elig = dreq_valid && db_free;

`ifdef MEM_ARB_STARVE_EN
  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign fetch_forced = (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

  // Count data grants that overtake a waiting fetch, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_f || !fetch_valid) begin
      starve_cnt <= '0;
    end else if (grant_d && !fetch_forced) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  // Grant selection in IDLE and transaction-state transitions.
  always_comb begin
    state_nxt = state;
    grant_f   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_elig && !(fetch_forced && f_elig)) begin
          grant_d   = 1'b1;
          state_nxt = DATA_WAIT;
        end else if (f_elig) begin
          grant_f   = 1'b1;
          state_nxt = FETCH_WAIT;
        end
      end
      FETCH_WAIT: if (mem_ack) state_nxt = IDLE;
      DATA_WAIT:  if (mem_ack) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign fetch_ready = grant_f;
  assign dreq_ready  = grant_d;
  assign ack_f       = (state == FETCH_WAIT) && mem_ack;
  assign ack_d       = (state == DATA_WAIT) && mem_ack;

  // Latch the granted request; the bus is driven only from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      tag_q   <= '0;
      store_q <= 1'b0;
    end else if (grant_f) begin
      req_q   <= 1'b1;
      addr_q  <= fetch_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
      store_q <= 1'b0;
    end else if (grant_d) begin
      req_q   <= 1'b1;
      addr_q  <= dreq_addr;
      we_q    <= dreq_store;
      wdata_q <= dreq_wdata;
      tag_q   <= dreq_tag;
      store_q <= dreq_store;
    end else if (ack_f || ack_d) begin
      req_q   <= 1'b0;
    end
  end

  // A flush during a fetch read marks its byte for dropping when it returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     squash <= 1'b0;
    else if (ack_f)                                 squash <= 1'b0;
    else if (fetch_flush && state == FETCH_WAIT)    squash <= 1'b1;
  end

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

  assign fb_push = ack_f && !squash && !fetch_flush;
  assign ld_data = store_q ? 8'h00 : mem_rdata;

  resp_buf1 #(.WIDTH(8)) u_fb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fetch_flush),
    .push      (fb_push),
    .push_data (mem_rdata),
    .free      (fb_free),
    .valid     (instr_valid),
    .data      (instr),
    .ready     (instr_ready)
  );

  resp_buf1 #(.WIDTH(DB_W)) u_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (ack_d),
    .push_data ({ld_data, tag_q, store_q}),
    .free      (db_free),
    .valid     (dresp_valid),
    .data      (db_out),
    .ready     (dresp_ready)
  );

  assign {dresp_data, dresp_tag, dresp_store} = db_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions,
// hand-written multi-cycle sequences, and a response scoreboard.
`ifndef PR_ADDR_W
`define PR_ADDR_W 6
`endif

module tb_mem_port_arbiter;

  localparam int TW = `PR_ADDR_W;

  logic          clk, rst_n;
  logic          fetch_valid, fetch_ready, fetch_flush;
  logic [15:0]   fetch_addr;
  logic [7:0]    instr;
  logic          instr_valid, instr_ready;
  logic          dreq_valid, dreq_ready, dreq_store;
  logic [15:0]   dreq_addr;
  logic [7:0]    dreq_wdata;
  logic [TW-1:0] dreq_tag;
  logic          dresp_valid, dresp_ready, dresp_store;
  logic [7:0]    dresp_data;
  logic [TW-1:0] dresp_tag;
  logic          mem_req, mem_we, mem_ack;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_flush(fetch_flush), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dreq_valid(dreq_valid), .dreq_ready(dreq_ready),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_store(dreq_store),
    .dreq_tag(dreq_tag), .dresp_valid(dresp_valid), .dresp_ready(dresp_ready),
    .dresp_data(dresp_data), .dresp_tag(dresp_tag), .dresp_store(dresp_store),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Memory behaviour: either a fixed byte or an address-derived byte.
  bit         use_fn = 0;
  logic [7:0] next_rdata = 8'h00;
  int         ack_lat = 1;
  int         mcnt = 0;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return use_fn ? mem_fn(a) : next_rdata;
  endfunction

  // Bus slave: one-cycle ack after ack_lat cycles of mem_req.
  always @(negedge clk) begin
    if (mem_ack || !rst_n) begin
      mem_ack = 1'b0;
      mcnt = 0;
    end else if (mem_req) begin
      mcnt++;
      if (mcnt >= ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_byte(mem_addr);
        mcnt      = 0;
      end
    end else begin
      mcnt = 0;
    end
  end

  // Scoreboard and bus monitor.
  logic [7:0]    fq[$];
  logic [TW+8:0] dq[$];
  byte           glog[$];
  logic [15:0]   cur_addr;
  logic          cur_we;
  logic [7:0]    cur_wdata;
  bit            exp_req_next = 0;
  bit            prev_ack = 0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      fq.delete();
      dq.delete();
      exp_req_next = 0;
      prev_ack = 0;
    end else begin
      if (exp_req_next) check("mem_req_rise", mem_req, 1);
      if (prev_ack) check("mem_req_fall", mem_req, 0);
      if (mem_req) begin
        check("mem_addr", mem_addr, cur_addr);
        check("mem_we", mem_we, cur_we);
        if (cur_we) check("mem_wdata", mem_wdata, cur_wdata);
      end
      if (fetch_valid && dreq_valid) check("one_ready", fetch_ready & dreq_ready, 0);
      if (fetch_flush) fq.delete();
      if (instr_valid && instr_ready) begin
        if (fq.size() == 0) check("sb_instr_unexpected", 1, 0);
        else check("sb_instr", instr, fq.pop_front());
      end
      if (dresp_valid && dresp_ready) begin
        if (dq.size() == 0) check("sb_dresp_unexpected", 1, 0);
        else check("sb_dresp", {dresp_data, dresp_tag, dresp_store}, dq.pop_front());
      end
      exp_req_next = 0;
      if (fetch_valid && fetch_ready) begin
        fq.push_back(mem_byte(fetch_addr));
        cur_addr = fetch_addr;
        cur_we = 1'b0;
        glog.push_back("F");
        exp_req_next = 1;
      end else if (dreq_valid && dreq_ready) begin
        dq.push_back({dreq_store ? 8'h00 : mem_byte(dreq_addr), dreq_tag, dreq_store});
        cur_addr = dreq_addr;
        cur_we = dreq_store;
        cur_wdata = dreq_wdata;
        glog.push_back("D");
        exp_req_next = 1;
      end
      prev_ack = mem_ack;
    end
  end

  typedef struct {
    bit            is_data;
    bit            store;
    logic [15:0]   addr;
    logic [7:0]    wdata;
    logic [TW-1:0] tag;
    logic [7:0]    rdata;
    int            lat;
    int            hold;
    bit            flush_g;
    logic [7:0]    exp_data;
  } vec_t;

  vec_t vecs[6];

  function automatic logic rv_of(input bit is_data);
    return is_data ? dresp_valid : instr_valid;
  endfunction

  function automatic logic [7:0] rd_of(input bit is_data);
    return is_data ? dresp_data : instr;
  endfunction

  task automatic run_vec(input vec_t v);
    int n;
    int cyc;
    use_fn = 0;
    next_rdata = v.rdata;
    ack_lat = v.lat;
    instr_ready = 0;
    dresp_ready = 0;
    @(negedge clk);
    if (v.is_data) begin
      dreq_valid = 1; dreq_addr = v.addr; dreq_wdata = v.wdata;
      dreq_store = v.store; dreq_tag = v.tag;
    end else begin
      fetch_valid = 1; fetch_addr = v.addr; fetch_flush = v.flush_g;
    end
    #1;
    n = 0;
    while (!(v.is_data ? dreq_ready : fetch_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("grant_seen", n < 20, 1);
    @(negedge clk);
    fetch_valid = 0; dreq_valid = 0; fetch_flush = 0;
    cyc = 1;
    #1;
    while (!rv_of(v.is_data) && cyc < 30) begin
      @(negedge clk); #1; cyc++;
    end
    check("resp_latency", cyc, v.lat + 1);
    check("resp_data", rd_of(v.is_data), v.exp_data);
    if (v.is_data) begin
      check("resp_tag", dresp_tag, v.tag);
      check("resp_store", dresp_store, v.store);
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk); #1;
      check("hold_valid", rv_of(v.is_data), 1);
      check("hold_data", rd_of(v.is_data), v.exp_data);
    end
    @(negedge clk);
    instr_ready = 1; dresp_ready = 1;
    @(negedge clk);
    instr_ready = 0; dresp_ready = 0;
    #1;
    check("resp_drained", rv_of(v.is_data), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    string exp_order;
    int n;
    bit seen;

    vecs[0] = '{0, 0, 16'h0200, 8'h00, TW'(0), 8'hA9, 2, 3, 0, 8'hA9};
    vecs[1] = '{1, 1, 16'h1234, 8'h55, TW'(7), 8'hC3, 2, 1, 0, 8'h00};
    vecs[2] = '{1, 0, 16'h2345, 8'h00, TW'(3), 8'h96, 1, 0, 0, 8'h96};
    vecs[3] = '{1, 0, 16'hFFFF, 8'h00, '1,     8'hFF, 4, 2, 0, 8'hFF};
    vecs[4] = '{0, 0, 16'h0000, 8'h00, TW'(0), 8'h5E, 1, 0, 1, 8'h5E};
    vecs[5] = '{1, 1, 16'h0001, 8'hAA, TW'(0), 8'h5A, 3, 0, 0, 8'h00};

    rst_n = 0;
    fetch_valid = 0; fetch_addr = '0; fetch_flush = 0; instr_ready = 0;
    dreq_valid = 0; dreq_addr = '0; dreq_wdata = '0; dreq_store = 0; dreq_tag = '0;
    dresp_ready = 0; mem_ack = 0; mem_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", |{mem_req, mem_we, mem_addr, mem_wdata, instr_valid, instr,
                             dresp_valid, dresp_data, dresp_tag, dresp_store,
                             fetch_ready, dreq_ready}, 0);
    fetch_valid = 1; #1;
    check("reset_fetch_ready", {fetch_ready, dreq_ready}, 2'b10);
    dreq_valid = 1; #1;
    check("reset_dreq_ready", {fetch_ready, dreq_ready}, 2'b01);
    fetch_valid = 0; dreq_valid = 0;
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Fetch squashed by a flush while its read is in flight.
    use_fn = 0; next_rdata = 8'hEA; ack_lat = 3; instr_ready = 1;
    @(negedge clk);
    fetch_valid = 1; fetch_addr = 16'h0400;
    #1;
    check("flush_grant", fetch_ready, 1);
    @(negedge clk);
    fetch_valid = 0; fetch_flush = 1;
    @(negedge clk);
    fetch_flush = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (instr_valid) seen = 1;
    end
    check("flush_no_instr", seen, 0);
    check("flush_bus_idle", mem_req, 0);
    instr_ready = 0;
    run_vec('{0, 0, 16'h0410, 8'h00, TW'(0), 8'h3C, 1, 0, 0, 8'h3C});

    // Both requesters held high: grant order.
    use_fn = 1; ack_lat = 1; instr_ready = 1; dresp_ready = 1;
    glog.delete();
    @(negedge clk);
    fetch_valid = 1; fetch_addr = 16'h0300;
    dreq_valid = 1; dreq_addr = 16'h2100; dreq_store = 0; dreq_tag = TW'(5);
    n = 0;
    do begin
      @(negedge clk); #3; n++;
    end while (glog.size() < 10 && n < 200);
    @(posedge clk); #1;
    fetch_valid = 0; dreq_valid = 0;
`ifdef MEM_ARB_STARVE_EN
    exp_order = "DDDDFDDDDF";
`else
    exp_order = "DDDDDDDDDD";
`endif
    check("order_count", glog.size() >= 10, 1);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      check("grant_order", glog[i], exp_order[i]);
    n = 0;
    while ((fq.size() != 0 || dq.size() != 0) && n < 20) begin
      @(negedge clk); n++;
    end
    check("order_drain", fq.size() + dq.size(), 0);

    // Data buffer full, consumer stalled: fetch takes the bus.
    dresp_ready = 0;
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 16'h2000; dreq_store = 0; dreq_tag = TW'(2);
    @(negedge clk);
    dreq_valid = 0;
    n = 0; #1;
    while (!dresp_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("bp_db_full", dresp_valid, 1);
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 16'h2001; dreq_tag = TW'(4);
    fetch_valid = 1; fetch_addr = 16'h0500;
    #1;
    check("bp_dreq_blocked", dreq_ready, 0);
    check("bp_fetch_wins", fetch_ready, 1);
    @(negedge clk);
    fetch_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    check("bp_dreq_still_blocked", dreq_ready, 0);
    check("bp_db_held", dresp_valid, 1);
    @(negedge clk);
    dresp_ready = 1;
    #1;
    check("bp_dreq_on_drain", dreq_ready, 1);
    @(negedge clk);
    dreq_valid = 0;
    n = 0;
    while ((fq.size() != 0 || dq.size() != 0) && n < 20) begin
      @(negedge clk); n++;
    end
    check("bp_drain", fq.size() + dq.size(), 0);
    dresp_ready = 0; instr_ready = 0;

    // Asynchronous reset while a load is in flight.
    use_fn = 0; next_rdata = 8'h77; ack_lat = 6;
    @(negedge clk);
    dreq_valid = 1; dreq_addr = 16'h3000; dreq_store = 0; dreq_tag = TW'(1);
    @(negedge clk);
    dreq_valid = 0;
    @(negedge clk); #1;
    check("rst_in_flight", mem_req, 1);
    rst_n = 0;
    #1;
    check("rst_async_outputs", |{mem_req, mem_we, mem_addr, mem_wdata, instr_valid, instr,
                                 dresp_valid, dresp_data, dresp_tag, dresp_store}, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rst_no_resp", dresp_valid, 0);
    run_vec(vecs[2]);

    repeat (3) @(negedge clk);
    check("final_queues_empty", fq.size() + dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
